// File: rtl/hack_mem_arbiter_if.sv
// Bus bundle for the Hack data-memory arbiter: two req/ack requester ports,
// the shared single-port memory side, and status.
interface hack_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/hack_mem_arbiter.sv
// Round-robin arbiter sharing one 16-bit single-port RAM between the Hack CPU
// data port and a loader; one access in flight, WAIT_STATES extra cycles each.
module hack_mem_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               reset,
    hack_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic          we_q;
    logic          owner_q;
    logic          last_grant;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rd_q;
    logic [DW-1:0] ldr_rd_q;
    logic          gnt;
    logic          gnt_sel;
    logic          cap;

    always_comb begin
        state_nxt = state;
        gnt       = 1'b0;
        gnt_sel   = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.ldr_req) begin
                    gnt       = 1'b1;
                    // On a tie the side that did not win last time goes next
                    gnt_sel   = (bus.cpu_req && bus.ldr_req) ? ~last_grant : bus.ldr_req;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    cap       = ~we_q;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 4'd0;
            we_q       <= 1'b0;
            owner_q    <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_rd_q   <= '0;
            ldr_rd_q   <= '0;
        end else begin
            if (gnt) begin
                cnt        <= 4'(WAIT_STATES);
                owner_q    <= gnt_sel;
                last_grant <= gnt_sel;
                we_q       <= gnt_sel ? bus.ldr_we    : bus.cpu_we;
                addr_q     <= gnt_sel ? bus.ldr_addr  : bus.cpu_addr;
                wdata_q    <= gnt_sel ? bus.ldr_wdata : bus.cpu_wdata;
            end
            if (state == ACCESS && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (cap) begin
                if (owner_q) ldr_rd_q <= bus.mem_rdata;
                else         cpu_rd_q <= bus.mem_rdata;
            end
        end
    end

    // Strobes decode straight from state so an async reset kills them at once
    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = (state == DONE) && !owner_q;
    assign bus.ldr_ack   = (state == DONE) &&  owner_q;
    assign bus.cpu_rdata = cpu_rd_q;
    assign bus.ldr_rdata = ldr_rd_q;
    assign bus.busy      = (state != IDLE);
    assign bus.owner     = owner_q;
endmodule

// File: doc/hack_mem_arbiter.md
Name: hack_mem_arbiter

Overview:
- Arbitrates one shared single-port 16-bit data memory between two requesters: the Hack CPU data port and a program/data loader (UART boot, DMA).
- Each requester uses a req/ack handshake; round-robin arbitration; one access in flight at a time.
- Drives the memory with a configurable number of wait states.
- Sits between the CPU's addressM/outM/writeM/inM signals and the RAM. The CPU-side glue holds its clock enable low until cpu_ack is high.

Parameters:
- AW, 16, address width of all address ports.
- DW, 16, data width of all data ports.
- WAIT_STATES, 1, extra memory cycles per access (0..15); an access occupies WAIT_STATES+1 cycles with mem_en high.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- cpu_req  in  1  CPU requests an access; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  AW  CPU address; stable while cpu_req is high.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data; valid in the cpu_ack cycle, held until the next CPU read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  same shapes and rules as the cpu_* ports, for the loader.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; only ever high while mem_en is high.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  requester being served (0 = CPU, 1 = loader); meaningful only while busy.

Behaviour:
- Reset values (immediate on reset=0, no clock needed):
  - FSM = IDLE.
  - cpu_ack = ldr_ack = mem_en = mem_we = busy = 0.
  - owner = 0; cpu_rdata = ldr_rdata = 0; mem_addr = mem_wdata = 0; wait counter = 0.
  - last_grant = 1 (loader), so the first tie goes to the CPU.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Only one req high: grant that requester.
  - Both high: grant the requester not equal to last_grant.
  - On grant:
    - Latch addr, wdata and we into mem_addr, mem_wdata and the internal we.
    - Set owner and last_grant to the granted requester.
    - Load the counter with WAIT_STATES.
    - Next state = ACCESS.
  - Neither high: stay in IDLE.
- ACCESS:
  - mem_en = 1; mem_we = latched we.
  - Counter != 0: decrement and stay in ACCESS.
  - Counter == 0: on a read, capture mem_rdata into the owner's rdata register; next state = DONE.
  - Memory contract: mem_rdata is valid by the edge ending the last ACCESS cycle. Address and data do not change during ACCESS.
- DONE:
  - The owner's ack = 1 for exactly this cycle; mem_en = 0.
  - req inputs are ignored in this cycle.
  - Next state = IDLE.
  - The requester drops req on the same edge it samples ack.
- Latency: req high in IDLE cycle t; ACCESS covers cycles t+1 .. t+1+WAIT_STATES; ack in cycle t+2+WAIT_STATES.
  - Back-to-back accesses repeat every WAIT_STATES+3 cycles.
- Writes: cpu_rdata and ldr_rdata are unchanged by writes.
- Fairness: with both requesters continuously requesting, grants strictly alternate. No requester waits more than one foreign access.
- A req that drops before being granted is ignored (no ack).
- Violations (req dropping or addr changing while the access is in flight): the already-latched access completes unchanged.
- Asynchronous reset mid-ACCESS:
  - mem_en and mem_we drop immediately.
  - The access is aborted and no ack is ever issued for it.
  - After reset is released, arbitration restarts from IDLE with last_grant = 1.
- Counter width is 4 bits; WAIT_STATES outside 0..15 is illegal.

Test Plan:
- Reset then idle; both reqs low for 10 cycles -> mem_en=0, busy=0, no ack, all outputs 0.
- WAIT_STATES=1; CPU write addr=0x0010, data=0xBEEF at cycle 0 -> mem_en=1, mem_we=1 in cycles 1-2 with mem_addr=0x0010 and mem_wdata=0xBEEF; cpu_ack=1 in cycle 3 only.
- Loader read addr=0x0010 with the memory model returning 0xBEEF -> ldr_ack in cycle 3 with ldr_rdata=0xBEEF; cpu_rdata unchanged.
- Both reqs high continuously for 4 accesses right after reset -> grant order CPU, LDR, CPU, LDR; acks every 4 cycles; owner toggles to match.
- WAIT_STATES=0; CPU read addr=0x7FFF -> mem_en high for exactly 1 cycle; cpu_ack in cycle 2.
- Reset asserted during the second ACCESS cycle of a loader write -> mem_en and mem_we fall without a clock edge; no ldr_ack; after release a CPU request is granted first.
